peakfinder: RTL and testbench

PEAKFINDER -- requirements
Module: peakfinder

---
 rtl/peakfinder.sv | 94 +++++++++
 tb/tb_peakfinder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/peakfinder.sv
// Streaming local-maximum detector: reports d1 when d1 > d2 and d1 >= the incoming sample.
// Optional minimum peak level enabled by defining PEAKFINDER_THRESH_EN.
module peakfinder #(
   parameter int unsigned               DATA_W      = 16,
   parameter int unsigned               NUM_SAMPLES = 42,
   parameter logic signed [DATA_W-1:0]  THRESH      = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] out_data,
   output logic              send_data,
   output logic              stop
);

   // Counter must hold NUM_SAMPLES and the constant 2 used by the history check.
   localparam int unsigned CNT_W = (NUM_SAMPLES < 3) ? 2 : int'($clog2(NUM_SAMPLES + 1));

`ifdef PEAKFINDER_THRESH_EN
   localparam bit THRESH_EN = 1'b1;
`else
   localparam bit THRESH_EN = 1'b0;
`endif

   logic [DATA_W-1:0] d1_q, d1_d;
   logic [DATA_W-1:0] d2_q, d2_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              send_data_q, send_data_d;
   logic              stop_q, stop_d;

   logic accept;
   logic hist_valid;
   logic last_sample;
   logic local_max;
   logic above_thresh;
   logic peak;

   always_comb begin
      accept       = ready && !stop_q;
      hist_valid   = (cnt_q >= CNT_W'(2));
      last_sample  = (cnt_q == CNT_W'(NUM_SAMPLES - 1));
      local_max    = ($signed(d1_q) > $signed(d2_q)) && ($signed(d1_q) >= $signed(in_data));
      above_thresh = !THRESH_EN || ($signed(d1_q) > THRESH);
      peak         = accept && hist_valid && local_max && above_thresh;
   end

   // Next-state: everything holds unless a sample is accepted; send_data is a one-cycle pulse.
   always_comb begin
      d1_d        = d1_q;
      d2_d        = d2_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      send_data_d = 1'b0;
      stop_d      = stop_q;

      if (accept) begin
         d2_d  = d1_q;
         d1_d  = in_data;
         cnt_d = cnt_q + CNT_W'(1);
         if (last_sample) begin
            stop_d = 1'b1;
         end
         if (peak) begin
            out_data_d  = d1_q;
            send_data_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d1_q        <= '0;
         d2_q        <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         send_data_q <= 1'b0;
         stop_q      <= 1'b0;
      end else begin
         d1_q        <= d1_d;
         d2_q        <= d2_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         send_data_q <= send_data_d;
         stop_q      <= stop_d;
      end
   end

   assign out_data  = out_data_q;
   assign send_data = send_data_q;
   assign stop      = stop_q;

endmodule

// File: tb/tb_peakfinder.sv
// Directed bench for peakfinder: vector table for short streams, hand sequence for the stop boundary.
module tb_peakfinder;

`ifdef PEAKFINDER_THRESH_EN
   localparam bit TEN = 1'b1;
`else
   localparam bit TEN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        ready;
   logic [15:0] in_data;
   logic [15:0] out_data;
   logic        send_data;
   logic        stop;

   int n_checks;
   int n_fail;

   typedef struct {
      logic        rst;
      logic        ready;
      logic [15:0] data;
      logic        exp_send;
      logic [15:0] exp_out;
      logic        exp_stop;
      string       name;
   } vec_t;

   vec_t vecs[$];

   peakfinder #(
      .DATA_W      (16),
      .NUM_SAMPLES (42),
      .THRESH      (16'sd5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ready     (ready),
      .in_data   (in_data),
      .out_data  (out_data),
      .send_data (send_data),
      .stop      (stop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input logic r, input logic rdy, input logic [15:0] d,
                               input logic es, input logic [15:0] eo, input logic est,
                               input string nm);
      vec_t v;
      v.rst = r; v.ready = rdy; v.data = d;
      v.exp_send = es; v.exp_out = eo; v.exp_stop = est; v.name = nm;
      vecs.push_back(v);
   endfunction

   // Drive on the falling edge, sample 1ns after the rising edge.
   task automatic step(input logic r, input logic rdy, input logic [15:0] d,
                       input logic es, input logic [15:0] eo, input logic est,
                       input string nm);
      @(negedge clk);
      rst     = r;
      ready   = rdy;
      in_data = d;
      @(posedge clk);
      #1;
      n_checks++;
      if (send_data !== es || out_data !== eo || stop !== est) begin
         n_fail++;
         $display("FAIL %s: got send=%0b out=%h stop=%0b, expected send=%0b out=%h stop=%0b",
                  nm, send_data, out_data, stop, es, eo, est);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      ready    = 1'b0;
      in_data  = '0;

      // Rising/falling ramp: single peak of 10 after the 4th accept.
      add(1, 0, 16'd0,  0, 16'd0,  0, "a_reset");
      add(0, 1, 16'd0,  0, 16'd0,  0, "a_s1");
      add(0, 1, 16'd5,  0, 16'd0,  0, "a_s2");
      add(0, 1, 16'd10, 0, 16'd0,  0, "a_s3");
      add(0, 1, 16'd5,  1, 16'd10, 0, "a_s4_peak");
      add(0, 1, 16'd0,  0, 16'd10, 0, "a_s5");
      add(0, 0, 16'd99, 0, 16'd10, 0, "a_idle_hold");

      // Negative samples: peak -3 (below threshold when enabled).
      add(1, 1, 16'd7,   0, 16'd0, 0, "b_reset");
      add(0, 1, 16'hFFF6, 0, 16'd0, 0, "b_s1_m10");
      add(0, 1, 16'hFFFD, 0, 16'd0, 0, "b_s2_m3");
      add(0, 1, 16'hFFF8, !TEN, TEN ? 16'd0 : 16'hFFFD, 0, "b_s3_peak_m3");
      add(0, 0, 16'd0,    0,    TEN ? 16'd0 : 16'hFFFD, 0, "b_idle_hold");

      // Plateau: reported once at its first sample.
      add(1, 0, 16'd0, 0, 16'd0, 0, "c_reset");
      add(0, 1, 16'd2, 0, 16'd0, 0, "c_s1");
      add(0, 1, 16'd7, 0, 16'd0, 0, "c_s2");
      add(0, 1, 16'd7, 1, 16'd7, 0, "c_s3_plateau_peak");
      add(0, 1, 16'd1, 0, 16'd7, 0, "c_s4_no_second");

      // Small peak of 3 versus THRESH=5.
      add(1, 0, 16'd0, 0, 16'd0, 0, "d_reset");
      add(0, 1, 16'd0, 0, 16'd0, 0, "d_s1");
      add(0, 1, 16'd3, 0, 16'd0, 0, "d_s2");
      add(0, 1, 16'd0, !TEN, TEN ? 16'd0 : 16'd3, 0, "d_s3_thresh");

      // 20 samples with peak 9, then reset and restart.
      add(1, 0, 16'd0, 0, 16'd0, 0, "e_reset");
      add(0, 1, 16'd1, 0, 16'd0, 0, "e_s1");
      add(0, 1, 16'd9, 0, 16'd0, 0, "e_s2");
      add(0, 1, 16'd2, 1, 16'd9, 0, "e_s3_peak9");
      for (int i = 0; i < 17; i++) add(0, 1, 16'(i + 3), 0, 16'd9, 0, "e_ramp");
      add(1, 1, 16'd30, 0, 16'd0, 0, "e_mid_reset");
      add(0, 1, 16'd50, 0, 16'd0, 0, "e_post_s1");
      add(0, 1, 16'd10, 0, 16'd0, 0, "e_post_s2");
      add(0, 1, 16'd20, 0, 16'd0, 0, "e_post_s3");

      foreach (vecs[k])
         step(vecs[k].rst, vecs[k].ready, vecs[k].data,
              vecs[k].exp_send, vecs[k].exp_out, vecs[k].exp_stop, vecs[k].name);

      // Full 42-sample run with a 3-cycle ready gap; the 42nd sample still evaluates d1.
      step(1, 0, 16'd0, 0, 16'd0, 0, "f_reset");
      for (int i = 0; i < 20; i++) step(0, 1, 16'(i), 0, 16'd0, 0, "f_ramp_lo");
      for (int i = 0; i < 3; i++)  step(0, 0, 16'h7FFF, 0, 16'd0, 0, "f_gap");
      for (int i = 20; i < 40; i++) step(0, 1, 16'(i), 0, 16'd0, 0, "f_ramp_hi");
      step(0, 1, 16'd100, 0, 16'd0,   0, "f_s41");
      step(0, 1, 16'd0,   1, 16'd100, 1, "f_s42_peak_stop");
      step(0, 1, 16'd500, 0, 16'd100, 1, "f_s43_ignored");
      step(0, 1, 16'd0,   0, 16'd100, 1, "f_s44_ignored");
      step(0, 0, 16'd0,   0, 16'd100, 1, "f_stop_held");
      step(1, 1, 16'd77,  0, 16'd0,   0, "f_reset_while_stop");
      step(0, 1, 16'd1,   0, 16'd0,   0, "f_restart_s1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
